forwarding_hazard_unit: RTL and testbench

- Parametrised successor to the pipeline's combinational forwarder.
- Tracks every in-flight writer from ID through EX, MEM and WB in internal shadow records.
- Forwards the newest matching result to NUM_READ_PORTS EX-stage operands.
- Detects load-use hazards and requests a one-cycle ID stall with EX bubble insertion. It sits beside the ID/EX pipeline registers; the datapath muxes operands from data_forwarded.

---
 rtl/forwarding_hazard_unit_if.sv | 34 +++
 rtl/forwarding_hazard_unit.sv | 106 ++++++++++
 tb/tb_forwarding_hazard_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/forwarding_hazard_unit_if.sv
// Bundle of ID/EX/MEM/WB signals shared by the pipeline and the forwarding/hazard unit.
// master = pipeline side driving stage info, slave = the forwarding_hazard_unit.
interface forwarding_hazard_unit_if #(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int bitwidth            = 32,
    parameter int NUM_READ_PORTS      = 2
);
    logic                                          hold;
    logic                                          flush;
    logic                                          id_valid;
    logic [REG_INDEX_BIT_WIDTH-1:0]                id_dst_index;
    logic                                          id_writes_reg;
    logic                                          id_is_load;
    logic [NUM_READ_PORTS*REG_INDEX_BIT_WIDTH-1:0] id_src_index;
    logic [NUM_READ_PORTS-1:0]                     id_src_used;
    logic [NUM_READ_PORTS*bitwidth-1:0]            ex_reg_data;
    logic [bitwidth-1:0]                           mem_data;
    logic [bitwidth-1:0]                           wb_data;
    logic [NUM_READ_PORTS*bitwidth-1:0]            data_forwarded;
    logic [2*NUM_READ_PORTS-1:0]                   fwd_sel;
    logic                                          load_use_stall;

    modport master (
        output hold, flush, id_valid, id_dst_index, id_writes_reg, id_is_load,
               id_src_index, id_src_used, ex_reg_data, mem_data, wb_data,
        input  data_forwarded, fwd_sel, load_use_stall
    );

    modport slave (
        input  hold, flush, id_valid, id_dst_index, id_writes_reg, id_is_load,
               id_src_index, id_src_used, ex_reg_data, mem_data, wb_data,
        output data_forwarded, fwd_sel, load_use_stall
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Tracks in-flight writers (EX/MEM/WB), forwards the newest result to EX operands and
// raises a one-cycle load-use stall. Define ZERO_REG_EN to hard-wire register 0 to zero.
module forwarding_hazard_unit #(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int bitwidth            = 32,
    parameter int NUM_READ_PORTS      = 2
) (
    input logic                    clk,
    input logic                    reset,
    forwarding_hazard_unit_if.slave bus
);
    localparam int RW = REG_INDEX_BIT_WIDTH;
    localparam int DW = bitwidth;
    localparam int NP = NUM_READ_PORTS;

`ifdef ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] dst;
        logic          wr;
        logic          ld;
    } stage_rec_t;

    // Load data is final once in WB, so the WB record needs no load flag.
    typedef struct packed {
        logic          valid;
        logic [RW-1:0] dst;
        logic          wr;
    } wb_rec_t;

    stage_rec_t              ex_rec;
    logic [NP-1:0][RW-1:0]   ex_src;
    logic [NP-1:0]           ex_used;
    stage_rec_t              mem_rec;
    wb_rec_t                 wb_rec;

    logic                    src_match;
    logic                    stall_raw;
    logic                    accept;

    function automatic logic is_zero(input logic [RW-1:0] idx);
        return ZERO_EN && (idx == '0);
    endfunction

    always_comb begin
        src_match = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (bus.id_src_used[p] && (bus.id_src_index[p*RW +: RW] == ex_rec.dst))
                src_match = 1'b1;
        end
        stall_raw = bus.id_valid && !bus.flush && ex_rec.valid && ex_rec.wr &&
                    ex_rec.ld && !is_zero(ex_rec.dst) && src_match;
        accept    = bus.id_valid && !bus.flush && !stall_raw;
    end

    assign bus.load_use_stall = stall_raw && !reset;

    // MEM beats WB because it holds the younger writer; loads in MEM have no data yet.
    always_comb begin
        bus.data_forwarded = '0;
        bus.fwd_sel        = '0;
        for (int p = 0; p < NP; p++) begin
            logic live;
            logic mem_hit;
            logic wb_hit;
            live    = ex_rec.valid && ex_used[p] && !is_zero(ex_src[p]);
            mem_hit = live && mem_rec.valid && mem_rec.wr && !mem_rec.ld &&
                      (mem_rec.dst == ex_src[p]);
            wb_hit  = live && wb_rec.valid && wb_rec.wr && (wb_rec.dst == ex_src[p]);
            if (mem_hit) begin
                bus.data_forwarded[p*DW +: DW] = bus.mem_data;
                bus.fwd_sel[2*p +: 2]          = 2'b01;
            end else if (wb_hit) begin
                bus.data_forwarded[p*DW +: DW] = bus.wb_data;
                bus.fwd_sel[2*p +: 2]          = 2'b10;
            end else begin
                bus.data_forwarded[p*DW +: DW] = bus.ex_reg_data[p*DW +: DW];
                bus.fwd_sel[2*p +: 2]          = 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rec.valid  <= 1'b0;
            mem_rec.valid <= 1'b0;
            wb_rec.valid  <= 1'b0;
        end else if (!bus.hold) begin
            wb_rec  <= '{valid: mem_rec.valid, dst: mem_rec.dst, wr: mem_rec.wr};
            mem_rec <= ex_rec;
            if (accept) begin
                ex_rec  <= '{valid: 1'b1, dst: bus.id_dst_index,
                             wr: bus.id_writes_reg, ld: bus.id_is_load};
                ex_src  <= bus.id_src_index;
                ex_used <= bus.id_src_used;
            end else begin
                ex_rec.valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Table-driven bench for forwarding_hazard_unit: each row drives one cycle of stage
// info and its expected outputs go through a scoreboard queue compared at negedge.
module tb_forwarding_hazard_unit;
    localparam logic [31:0] ER0 = 32'h1000_0001;
    localparam logic [31:0] ER1 = 32'h2000_0002;
    localparam logic [31:0] M   = 32'h3333_3333;
    localparam logic [31:0] W   = 32'h4444_4444;

    typedef struct {
        logic        rst, hold, flush, idv;
        logic [3:0]  dst;
        logic        wr, ld;
        logic [3:0]  s0, s1;
        logic [1:0]  used;
        logic [31:0] mem, wb;
        logic [3:0]  exp_sel;
        logic [31:0] exp_d0, exp_d1;
        logic        exp_stall;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  sel;
        logic [31:0] d0, d1;
        logic        stall;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   vec_no = 0;
    exp_t sb[$];
    vec_t tbl[$];
    vec_t hand[$];

    forwarding_hazard_unit_if #(.REG_INDEX_BIT_WIDTH(4), .bitwidth(32), .NUM_READ_PORTS(2)) bus ();

    forwarding_hazard_unit #(.REG_INDEX_BIT_WIDTH(4), .bitwidth(32), .NUM_READ_PORTS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, hold, flush, idv, input logic [3:0] dst,
                                input logic wr, ld, input logic [3:0] s0, s1,
                                input logic [1:0] used, input logic [31:0] mem, wb,
                                input logic [3:0] sel, input logic [31:0] d0, d1,
                                input logic stall);
        vec_t v;
        v.rst = rst; v.hold = hold; v.flush = flush; v.idv = idv;
        v.dst = dst; v.wr = wr; v.ld = ld; v.s0 = s0; v.s1 = s1; v.used = used;
        v.mem = mem; v.wb = wb;
        v.exp_sel = sel; v.exp_d0 = d0; v.exp_d1 = d1; v.exp_stall = stall;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        reset             = v.rst;
        bus.hold          = v.hold;
        bus.flush         = v.flush;
        bus.id_valid      = v.idv;
        bus.id_dst_index  = v.dst;
        bus.id_writes_reg = v.wr;
        bus.id_is_load    = v.ld;
        bus.id_src_index  = {v.s1, v.s0};
        bus.id_src_used   = v.used;
        bus.ex_reg_data   = {ER1, ER0};
        bus.mem_data      = v.mem;
        bus.wb_data       = v.wb;
        e.idx   = vec_no;
        e.sel   = v.exp_sel;
        e.d0    = v.exp_d0;
        e.d1    = v.exp_d1;
        e.stall = v.exp_stall;
        sb.push_back(e);
        vec_no++;
    endtask

    task automatic checkValue(input string name, input int idx, input logic [31:0] act,
                              input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            checkValue("fwd_sel", e.idx, {28'd0, bus.fwd_sel}, {28'd0, e.sel});
            checkValue("data_p0", e.idx, bus.data_forwarded[31:0], e.d0);
            checkValue("data_p1", e.idx, bus.data_forwarded[63:32], e.d1);
            checkValue("stall", e.idx, {31'd0, bus.load_use_stall}, {31'd0, e.stall});
        end
    endtask

    task automatic runRows(input vec_t rows[$]);
        foreach (rows[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(rows[i]);
            @(negedge clk);
            checkOutput();
        end
    endtask

    initial begin
        // Reset corner: a load r3 sits in EX while reset rises with a consumer in ID.
        hand.push_back(mk(0,0,0,1, 3,1,1, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));
        hand.push_back(mk(1,0,0,1, 8,1,0, 3,0,2'b01, M,W, 4'h0, ER0,ER1, 0));
        hand.push_back(mk(1,0,0,1, 8,1,0, 3,0,2'b01, M,W, 4'h0, ER0,ER1, 0));
        hand.push_back(mk(0,0,0,0, 0,0,0, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));

        // EX->MEM forward: ADD r5; SUB r6,r5,r2
        tbl.push_back(mk(0,0,0,1, 5,1,0, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,1, 6,1,0, 5,2,2'b11, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,2'b00, 32'hAA,W, 4'b0001, 32'hAA,ER1, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));
        // Double hit on r4: MEM wins
        tbl.push_back(mk(0,0,0,1, 4,1,0, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,1, 4,1,0, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,1, 9,1,0, 4,1,2'b11, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,2'b00, 32'h11,32'h22, 4'b0001, 32'h11,ER1, 0));
        // Load-use: LW r7; ADD r8,r7,r1
        tbl.push_back(mk(0,0,0,1, 7,1,1, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,1, 8,1,0, 7,1,2'b11, M,W, 4'h0, ER0,ER1, 1));
        tbl.push_back(mk(0,0,0,1, 8,1,0, 7,1,2'b11, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,2'b00, 32'h55,32'hDEAD_BEEF, 4'b0010, 32'hDEAD_BEEF,ER1, 0));
        // Flush together with hazard
        tbl.push_back(mk(0,0,0,1, 7,1,1, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,1,1, 10,1,0, 7,0,2'b01, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,2'b00, 32'h77,32'h88, 4'h0, ER0,ER1, 0));
        // Stall held across hold cycles: LW r3; ADD r11,r1,r3 (port1 only)
        tbl.push_back(mk(0,0,0,1, 3,1,1, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,1,0,1, 11,1,0, 1,3,2'b10, M,W, 4'h0, ER0,ER1, 1));
        tbl.push_back(mk(0,1,0,1, 11,1,0, 1,3,2'b10, M,W, 4'h0, ER0,ER1, 1));
        tbl.push_back(mk(0,0,0,1, 11,1,0, 1,3,2'b10, M,W, 4'h0, ER0,ER1, 1));
        tbl.push_back(mk(0,0,0,1, 11,1,0, 1,3,2'b10, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,2'b00, M,32'hCAFE_0003, 4'b1000, ER0,32'hCAFE_0003, 0));
        // Register 0 writer in MEM, consumer reads r0; then freeze with hold
        tbl.push_back(mk(0,0,0,1, 0,1,0, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,1, 12,1,0, 0,2,2'b11, M,W, 4'h0, ER0,ER1, 0));
`ifdef ZERO_REG_EN
        tbl.push_back(mk(0,1,0,0, 0,0,0, 0,0,2'b00, 32'h5,W, 4'h0, ER0,ER1, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,2'b00, 32'h6,W, 4'h0, ER0,ER1, 0));
`else
        tbl.push_back(mk(0,1,0,0, 0,0,0, 0,0,2'b00, 32'h5,W, 4'b0001, 32'h5,ER1, 0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,2'b00, 32'h6,W, 4'b0001, 32'h6,ER1, 0));
`endif
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));

        reset = 1'b1;
        applyStimulus(mk(1,0,0,0, 0,0,0, 0,0,2'b00, M,W, 4'h0, ER0,ER1, 0));
        void'(sb.pop_back());
        repeat (2) @(posedge clk);

        runRows(hand);
        runRows(tbl);

        if (sb.size() != 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
